// File: rtl/compressor_pkg.sv
// Shared types and helpers for the multichannel compressor: FSM states,
// channel-index sizing and a saturating absolute value.
package compressor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENV,
    LINK,
    MUL,
    APPLY,
    DONE
  } state_t;

  localparam int MAX_CHANNELS = 20;

  // Width of the channel index, $clog2(channels) but never narrower than one bit.
  function automatic int idx_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // |x| for a bits-wide sample held sign-extended in 32 bits; the most negative
  // value maps to the most positive one so the magnitude always fits in bits.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int bits);
    logic signed [31:0] most_neg;
    most_neg = -(32'sd1 <<< (bits - 1));
    if (x == most_neg) begin
      return 32'((32'sd1 <<< (bits - 1)) - 32'sd1);
    end else if (x < 0) begin
      return 32'(-x);
    end else begin
      return 32'(x);
    end
  endfunction

endpackage

// File: rtl/frac_mult.sv
// Registered unsigned fractional multiplier: p = (a * b) >> W, one cycle latency.
module frac_mult #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);

  logic [2*W-1:0] full;

  assign full = {{W{1'b0}}, a} * {{W{1'b0}}, b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else begin
      p <= W'(full >> W);
    end
  end

endmodule

// File: rtl/multichannel_compressor.sv
// N-channel peak-envelope dynamic-range compressor; channels are processed
// serially per lrclk frame and share a single fractional multiplier.
module multichannel_compressor
  import compressor_pkg::*;
#(
  parameter int BITSIZE       = 16,
  parameter int CHANNELS      = 2,
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 10
) (
  input  logic                         bclk,
  input  logic                         rst_n,
  input  logic                         lrclk,
  input  logic [CHANNELS*BITSIZE-1:0]  in,
  input  logic [BITSIZE-1:0]           thr,
  input  logic [BITSIZE-1:0]           ratio,
  input  logic                         link,
  output logic [CHANNELS*BITSIZE-1:0]  out,
  output logic                         out_valid,
  output logic                         overrun
);

  localparam int IDX_W = idx_width(CHANNELS);

  typedef logic [BITSIZE-1:0] word_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg;
  logic             lr_q_reg;
  logic             start_reg;
  logic             link_reg;
  logic             out_valid_reg;
  logic             overrun_reg;
  word_t            thr_reg;
  word_t            ratio_reg;
  word_t            excess_reg;
  word_t            in_cap_reg [CHANNELS];
  word_t            env_reg    [CHANNELS];
  word_t            e_reg      [CHANNELS];
  word_t            shadow_reg [CHANNELS];
  word_t            out_reg    [CHANNELS];

  logic  frame_edge, busy, accept, last_ch;
  word_t cur_in, cur_abs, cur_env, cur_e;
  word_t env_new, env_step, env_max;
  word_t excess, kept, red, red_lim, apply_result;

  assign frame_edge = lrclk & ~lr_q_reg;
  // The capture cycle itself counts as busy so a frame is never half-accepted.
  assign busy       = (state_reg != IDLE) | start_reg;
  assign accept     = frame_edge & ~busy;
  assign last_ch    = (idx_reg == IDX_W'(CHANNELS - 1));

  assign cur_in  = in_cap_reg[idx_reg];
  assign cur_abs = BITSIZE'(sat_abs(32'(signed'(cur_in)), BITSIZE));
  assign cur_env = env_reg[idx_reg];
  assign cur_e   = e_reg[idx_reg];

  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      lr_q_reg    <= 1'b0;
      start_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      thr_reg     <= '0;
      ratio_reg   <= '0;
      link_reg    <= 1'b0;
    end else begin
      lr_q_reg  <= lrclk;
      start_reg <= accept;
      if (frame_edge && busy) begin
        overrun_reg <= 1'b1;
      end
      if (accept) begin
        thr_reg   <= thr;
        ratio_reg <= ratio;
        link_reg  <= link;
      end
    end
  end

  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_reg) state_next = ENV;
      ENV:     if (last_ch) state_next = LINK;
      LINK:    state_next = MUL;
      MUL:     state_next = APPLY;
      APPLY:   state_next = last_ch ? DONE : MUL;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg <= '0;
    end else if (state_reg == ENV || state_reg == APPLY) begin
      idx_reg <= last_ch ? '0 : idx_reg + IDX_W'(1);
    end else if (state_reg == IDLE) begin
      idx_reg <= '0;
    end
  end

  // Step is at least 1 and never exceeds the gap, so the envelope cannot overshoot.
  always_comb begin
    env_new  = cur_env;
    env_step = '0;
    if (cur_abs > cur_env) begin
      env_step = (cur_abs - cur_env) >> ATTACK_SHIFT;
      if (env_step == '0) env_step = word_t'(1);
      env_new = cur_env + env_step;
    end else if (cur_abs < cur_env) begin
      env_step = (cur_env - cur_abs) >> RELEASE_SHIFT;
      if (env_step == '0) env_step = word_t'(1);
      env_new = cur_env - env_step;
    end
  end

  always_comb begin
    env_max = env_reg[0];
    for (int i = 1; i < CHANNELS; i++) begin
      if (env_reg[i] > env_max) env_max = env_reg[i];
    end
  end

  assign excess = (cur_e > thr_reg) ? (cur_e - thr_reg) : '0;

  frac_mult #(
    .W (BITSIZE)
  ) u_frac_mult (
    .clk   (bclk),
    .rst_n (rst_n),
    .a     (excess),
    .b     (ratio_reg),
    .p     (kept)
  );

  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      excess_reg <= '0;
    end else if (state_reg == MUL) begin
      excess_reg <= excess;
    end
  end

  // Clamping the reduction to the sample magnitude keeps the output from crossing zero.
  assign red          = excess_reg - kept;
  assign red_lim      = (red > cur_abs) ? cur_abs : red;
  assign apply_result = cur_in[BITSIZE-1] ? (cur_in + red_lim) : (cur_in - red_lim);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    always_ff @(posedge bclk or negedge rst_n) begin
      if (!rst_n) begin
        in_cap_reg[gi] <= '0;
        env_reg[gi]    <= '0;
        e_reg[gi]      <= '0;
        shadow_reg[gi] <= '0;
        out_reg[gi]    <= '0;
      end else begin
        if (accept) in_cap_reg[gi] <= in[gi*BITSIZE +: BITSIZE];
        if (state_reg == ENV && idx_reg == IDX_W'(gi)) env_reg[gi] <= env_new;
        if (state_reg == LINK) e_reg[gi] <= link_reg ? env_max : env_reg[gi];
        if (state_reg == APPLY && idx_reg == IDX_W'(gi)) shadow_reg[gi] <= apply_result;
        if (state_reg == DONE) out_reg[gi] <= shadow_reg[gi];
      end
    end
    assign out[gi*BITSIZE +: BITSIZE] = out_reg[gi];
  end

  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= (state_reg == DONE);
    end
  end

  assign out_valid = out_valid_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_multichannel_compressor.sv
// Directed bench for multichannel_compressor (B=16, C=2, attack shift 0, release shift 10).
module tb_multichannel_compressor;

  logic        bclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lrclk = 1'b0;
  logic [31:0] in_bus = '0;
  logic [15:0] thr = '0;
  logic [15:0] ratio = '0;
  logic        link = 1'b0;
  logic [31:0] out_bus;
  logic        out_valid;
  logic        overrun;

  int total = 0;
  int bad = 0;

  multichannel_compressor #(
    .BITSIZE       (16),
    .CHANNELS      (2),
    .ATTACK_SHIFT  (0),
    .RELEASE_SHIFT (10)
  ) dut (
    .bclk      (bclk),
    .rst_n     (rst_n),
    .lrclk     (lrclk),
    .in        (in_bus),
    .thr       (thr),
    .ratio     (ratio),
    .link      (link),
    .out       (out_bus),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  always #5 bclk = ~bclk;

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  task automatic do_reset();
    @(negedge bclk);
    rst_n = 1'b0;
    lrclk = 1'b0;
    repeat (3) @(negedge bclk);
    rst_n = 1'b1;
    @(negedge bclk);
  endtask

  // One frame: raise lrclk, scramble the live inputs after capture, then watch
  // 20 cycles for out_valid. vcyc is the edge index (after E) of the first pulse.
  task automatic run_frame(input logic [15:0] c0, input logic [15:0] c1,
                           input logic [15:0] t, input logic [15:0] r, input logic lk,
                           output logic [15:0] o0, output logic [15:0] o1,
                           output int vcyc, output int pulses);
    o0 = 'x; o1 = 'x; vcyc = -1; pulses = 0;
    @(negedge bclk);
    in_bus = {c1, c0}; thr = t; ratio = r; link = lk; lrclk = 1'b1;
    @(posedge bclk);
    @(negedge bclk);
    lrclk = 1'b0;
    in_bus = 32'h1357_9BDF; thr = 16'h0000; ratio = 16'h0000; link = ~lk;
    for (int n = 1; n <= 20; n++) begin
      @(posedge bclk); #1;
      if (out_valid === 1'b1) begin
        pulses++;
        if (vcyc < 0) begin
          vcyc = n; o0 = out_bus[15:0]; o1 = out_bus[31:16];
        end
      end
    end
    $display("frame in=%h/%h thr=%h ratio=%h link=%0d -> out=%h/%h valid@%0d pulses=%0d",
             c0, c1, t, r, lk, o0, o1, vcyc, pulses);
  endtask

  logic [15:0] o0, o1;
  int vcyc, pulses;

  task automatic test_reset();
    do_reset();
    check16("reset_out0", out_bus[15:0], 16'h0000);
    check16("reset_out1", out_bus[31:16], 16'h0000);
    check16("reset_valid", {15'd0, out_valid}, 16'h0000);
    check16("reset_overrun", {15'd0, overrun}, 16'h0000);
  endtask

  task automatic test_basic();
    do_reset();
    run_frame(16'h6000, 16'hA000, 16'h4000, 16'h8000, 1'b0, o0, o1, vcyc, pulses);
    check16("basic_out0", o0, 16'h5000);
    check16("basic_out1", o1, 16'hB000);
    check16("basic_latency", 16'(vcyc), 16'd9);
    check16("basic_pulses", 16'(pulses), 16'd1);
  endtask

  task automatic test_below_threshold();
    do_reset();
    run_frame(16'h1234, 16'h0000, 16'h4000, 16'h8000, 1'b0, o0, o1, vcyc, pulses);
    check16("below_out0", o0, 16'h1234);
    check16("below_out1", o1, 16'h0000);
  endtask

  task automatic test_link();
    do_reset();
    run_frame(16'h6000, 16'h2000, 16'h4000, 16'h8000, 1'b1, o0, o1, vcyc, pulses);
    check16("link1_out0", o0, 16'h5000);
    check16("link1_out1", o1, 16'h1000);
    do_reset();
    run_frame(16'h6000, 16'h2000, 16'h4000, 16'h8000, 1'b0, o0, o1, vcyc, pulses);
    check16("link0_out0", o0, 16'h5000);
    check16("link0_out1", o1, 16'h2000);
  endtask

  // env 0x6000 -> 0x5FE8 after a silent frame; a third frame at 0x5FE8 exposes it.
  task automatic test_release();
    do_reset();
    run_frame(16'h6000, 16'h0000, 16'h4000, 16'h8000, 1'b0, o0, o1, vcyc, pulses);
    check16("release_f1_out0", o0, 16'h5000);
    run_frame(16'h0000, 16'h0000, 16'h4000, 16'h8000, 1'b0, o0, o1, vcyc, pulses);
    check16("release_f2_out0", o0, 16'h0000);
    run_frame(16'h5FE8, 16'h0000, 16'h4000, 16'h8000, 1'b0, o0, o1, vcyc, pulses);
    check16("release_f3_out0", o0, 16'h4FF4);
  endtask

  task automatic test_ratio_extremes();
    do_reset();
    run_frame(16'h6000, 16'h8000, 16'h4000, 16'h0000, 1'b0, o0, o1, vcyc, pulses);
    check16("hardlimit_out0", o0, 16'h4000);
    check16("hardlimit_out1", o1, 16'hBFFF);
    do_reset();
    run_frame(16'h6000, 16'h0000, 16'h4000, 16'hFFFF, 1'b0, o0, o1, vcyc, pulses);
    check16("ratio_ones_out0", o0, 16'h5FFF);
  endtask

  task automatic test_saturation();
    do_reset();
    run_frame(16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 1'b0, o0, o1, vcyc, pulses);
    check16("sat_out0", o0, 16'h8000);
    check16("sat_out1", o1, 16'h7FFF);
    run_frame(16'h7FFF, 16'h8001, 16'h8000, 16'h0000, 1'b0, o0, o1, vcyc, pulses);
    check16("passthru_out0", o0, 16'h7FFF);
    check16("passthru_out1", o1, 16'h8001);
  endtask

  task automatic test_overrun();
    int p = 0;
    int vc = -1;
    logic [15:0] r0 = 'x;
    logic [15:0] r1 = 'x;
    do_reset();
    @(negedge bclk);
    in_bus = {16'hA000, 16'h6000}; thr = 16'h4000; ratio = 16'h8000; link = 1'b0; lrclk = 1'b1;
    @(posedge bclk);
    @(negedge bclk);
    lrclk = 1'b0;
    in_bus = 32'h7777_7777;
    for (int n = 1; n <= 20; n++) begin
      @(posedge bclk); #1;
      if (n == 3) lrclk = 1'b1;
      if (n == 4) lrclk = 1'b0;
      if (out_valid === 1'b1) begin
        p++;
        if (vc < 0) begin
          vc = n; r0 = out_bus[15:0]; r1 = out_bus[31:16];
        end
      end
    end
    $display("overrun frame -> out=%h/%h valid@%0d pulses=%0d overrun=%0d", r0, r1, vc, p, overrun);
    check16("overrun_out0", r0, 16'h5000);
    check16("overrun_out1", r1, 16'hB000);
    check16("overrun_latency", 16'(vc), 16'd9);
    check16("overrun_pulses", 16'(p), 16'd1);
    check16("overrun_flag", {15'd0, overrun}, 16'h0001);
  endtask

  // Relies on the nonzero out left by test_overrun.
  task automatic test_reset_mid_frame();
    int p = 0;
    @(negedge bclk);
    in_bus = {16'hA000, 16'h6000}; thr = 16'h4000; ratio = 16'h8000; link = 1'b0; lrclk = 1'b1;
    @(posedge bclk);
    @(negedge bclk);
    lrclk = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge bclk); #1;
      if (n == 4) rst_n = 1'b0;
      if (n == 5) begin
        check16("midrst_out0", out_bus[15:0], 16'h0000);
        check16("midrst_out1", out_bus[31:16], 16'h0000);
        check16("midrst_overrun", {15'd0, overrun}, 16'h0000);
      end
      if (n == 6) rst_n = 1'b1;
      if (out_valid === 1'b1) p++;
    end
    $display("mid-frame reset -> out=%h pulses=%0d", out_bus, p);
    check16("midrst_pulses", 16'(p), 16'd0);
    check16("midrst_out_after", out_bus[15:0], 16'h0000);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_below_threshold();
    test_link();
    test_release();
    test_ratio_extremes();
    test_saturation();
    test_overrun();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
